// File: rtl/ai_task_queue.sv
// ai_task_queue: task FIFO with lowest-idle-unit dispatch, completion tracking and a register window.
module ai_task_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int NUM_UNITS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      task_valid,
    input  logic [7:0]                task_id,
    input  logic [7:0]                task_type,
    output logic                      task_ready,
    output logic                      task_done,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   be,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      ready,
    output logic                      error,
    output logic [NUM_UNITS-1:0]      disp_valid,
    output logic [7:0]                disp_id,
    output logic [7:0]                disp_type,
    input  logic [NUM_UNITS-1:0]      unit_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;

    logic [15:0]           mem_q [DEPTH];
    logic [7:0]            unit_id_q [NUM_UNITS];
    logic [AW-1:0]         wr_q, rd_q;
    logic [AW:0]           count_q, count_d;
    logic [NUM_UNITS-1:0]  busy_q, busy_d, idle, sel_oh, done_eff, disp_valid_q;
    logic [UW-1:0]         sel;
    logic [31:0]           done_cnt_q, done_cnt_d;
    logic [7:0]            last_id_q, last_id_d, disp_id_q, disp_type_q;
    logic [3:0]            ncomp;
    logic [15:0]           head;
    logic [DATA_WIDTH-1:0] rd_d, rdata_q;
    logic                  enable_q, enable_d, err_q, err_d, task_ready_q, task_ready_d, task_done_q;
    logic                  ready_q, error_q, acc, wr, a_ctrl, a_stat, a_cnt, a_last, mapped;
    logic                  flush, push, pop;
    logic                  unused_ok;

    assign unused_ok = ^{wdata[DATA_WIDTH-1:17], wdata[15:2], be[DATA_WIDTH/8-1:1]};

    assign head   = mem_q[rd_q];
    assign acc    = req && !ready_q;
    assign wr     = acc && we;
    assign a_ctrl = addr == ADDR_WIDTH'(0);
    assign a_stat = addr == ADDR_WIDTH'(8);
    assign a_cnt  = addr == ADDR_WIDTH'(16);
    assign a_last = addr == ADDR_WIDTH'(24);
    assign mapped = a_ctrl || a_stat || a_cnt || a_last;

    always_comb begin
        idle     = ~busy_q;
        sel_oh   = idle & (~idle + NUM_UNITS'(1));
        sel      = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--)
            if (idle[i]) sel = UW'(i);
        flush    = wr && a_ctrl && be[0] && wdata[1];
        enable_d = (wr && a_ctrl && be[0]) ? wdata[0] : enable_q;
        push     = task_valid && task_ready_q && !flush;
        pop      = (count_q != '0) && (|idle) && !flush;
        count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        task_ready_d = enable_d && (count_d < (AW+1)'(DEPTH));
        done_eff = unit_done & busy_q;
        busy_d   = (busy_q & ~done_eff) | (pop ? sel_oh : '0);
        ncomp    = '0;
        last_id_d = last_id_q;
        // ascending scan so the highest-index completing unit wins
        for (int i = 0; i < NUM_UNITS; i++) begin
            ncomp = ncomp + 4'(done_eff[i]);
            if (done_eff[i]) last_id_d = unit_id_q[i];
        end
        done_cnt_d = done_cnt_q + 32'(ncomp);
        err_d = (|(unit_done & ~busy_q)) || (err_q && !(wr && a_stat && wdata[16]));
        rd_d = '0;
        rd_d[0] = a_ctrl && enable_q;
        if (a_stat) begin
            rd_d[7:0]  = 8'(count_q);
            rd_d[15:8] = 8'(busy_q);
            rd_d[16]   = err_q;
        end
        if (a_cnt) rd_d[31:0] = done_cnt_q;
        if (a_last) rd_d[7:0] = last_id_q;
    end

    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= {task_id, task_type};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            done_cnt_q   <= '0;
            last_id_q    <= '0;
            err_q        <= 1'b0;
            enable_q     <= 1'b1;
            task_ready_q <= 1'b0;
            task_done_q  <= 1'b0;
            disp_valid_q <= '0;
            disp_id_q    <= '0;
            disp_type_q  <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            rdata_q      <= '0;
            for (int i = 0; i < NUM_UNITS; i++) unit_id_q[i] <= '0;
        end else begin
            wr_q         <= push ? wr_q + AW'(1) : wr_q;
            rd_q         <= flush ? wr_q : (pop ? rd_q + AW'(1) : rd_q);
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_cnt_q   <= done_cnt_d;
            last_id_q    <= last_id_d;
            err_q        <= err_d;
            enable_q     <= enable_d;
            task_ready_q <= task_ready_d;
            task_done_q  <= |done_eff;
            disp_valid_q <= pop ? sel_oh : '0;
            if (pop) begin
                disp_id_q      <= head[15:8];
                disp_type_q    <= head[7:0];
                unit_id_q[sel] <= head[15:8];
            end
            ready_q <= acc;
            error_q <= acc && !mapped;
            rdata_q <= (acc && mapped) ? rd_d : '0;
        end
    end

    assign task_ready = task_ready_q;
    assign task_done  = task_done_q;
    assign disp_valid = disp_valid_q;
    assign disp_id    = disp_id_q;
    assign disp_type  = disp_type_q;
    assign rdata      = rdata_q;
    assign ready      = ready_q;
    assign error      = error_q;
endmodule

// File: tb/tb_ai_task_queue.sv
// tb_ai_task_queue: directed vectors with hand-computed expectations for ai_task_queue.
module tb_ai_task_queue;
    logic        clk = 0, rst_n = 0;
    logic        task_valid = 0, task_ready, task_done;
    logic [7:0]  task_id = 0, task_type = 0, disp_id, disp_type;
    logic        req = 0, we = 0, ready, error;
    logic [31:0] addr = 0;
    logic [63:0] wdata = 0, rdata;
    logic [7:0]  be = 8'hFF;
    logic [3:0]  disp_valid, unit_done = 0;
    int          n_vec = 0, n_err = 0;
    logic [63:0] rd;
    logic        e;

    ai_task_queue dut (
        .clk(clk), .rst_n(rst_n), .task_valid(task_valid), .task_id(task_id), .task_type(task_type),
        .task_ready(task_ready), .task_done(task_done), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .rdata(rdata), .ready(ready), .error(error),
        .disp_valid(disp_valid), .disp_id(disp_id), .disp_type(disp_type), .unit_done(unit_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_acc(input logic w, input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] b, output logic [63:0] r, output logic er);
        logic got = 0;
        req = 1; we = w; addr = a; wdata = d; be = b;
        r = '0; er = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ready) begin got = 1; r = rdata; er = error; end
        end
        req = 0; we = 0;
        if (!got) chk("reg_timeout", 0, 1);
    endtask

    task automatic push(input logic [7:0] id);
        task_valid = 1; task_id = id; task_type = id ^ 8'hA0;
        step();
    endtask

    initial begin
        int k;
        logic acc;
        step(); step();
        chk("rst_task_ready", task_ready, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_task_done", task_done, 0);
        chk("rst_ready", ready, 0);
        rst_n = 1; step();
        chk("ready_after_rst", task_ready, 1);

        push(8'h11); push(8'h22);
        chk("disp0_valid", disp_valid, 4'b0001);
        chk("disp0_id", disp_id, 8'h11);
        chk("disp0_type", disp_type, 8'hB1);
        task_valid = 0; step();
        chk("disp1_valid", disp_valid, 4'b0010);
        chk("disp1_id", disp_id, 8'h22);
        step();
        chk("disp_idle", disp_valid, 0);
        chk("disp_id_hold", disp_id, 8'h22);
        reg_acc(0, 32'h08, 0, 8'hFF, rd, e);
        chk("status_a", rd, 64'h0300);

        rst_n = 0; step(); rst_n = 1; step();
        push(8'h05); push(8'h06); push(8'h08); push(8'h07);
        task_valid = 0; step(); step();
        unit_done = 4'b1001; step(); unit_done = 0;
        chk("multi_done_pulse", task_done, 1);
        step();
        chk("multi_done_once", task_done, 0);
        reg_acc(0, 32'h10, 0, 8'hFF, rd, e);
        chk("done_cnt_2", rd, 2);
        reg_acc(0, 32'h18, 0, 8'hFF, rd, e);
        chk("last_id_07", rd, 8'h07);
        unit_done = 4'b0001; step(); unit_done = 0;
        reg_acc(0, 32'h08, 0, 8'hFF, rd, e);
        chk("status_err", rd, 64'h1_0600);
        reg_acc(1, 32'h08, 64'h1_0000, 8'hFF, rd, e);
        reg_acc(0, 32'h08, 0, 8'hFF, rd, e);
        chk("status_err_clr", rd, 64'h0600);

        push(8'h30); push(8'h31); task_valid = 0; step(); step();
        k = 0;
        task_valid = 1; task_id = 8'h40; task_type = 8'hE0;
        for (int i = 0; i < 12; i++) begin
            acc = task_ready;
            step();
            if (acc) k++;
            task_id = 8'(8'h40 + k); task_type = task_id ^ 8'hA0;
        end
        chk("full_accepts", k, 8);
        chk("full_not_ready", task_ready, 0);
        reg_acc(0, 32'h08, 0, 8'hFF, rd, e);
        chk("status_full", rd, 64'h0F08);
        unit_done = 4'b0100; step(); unit_done = 0; step();
        chk("full_disp_valid", disp_valid, 4'b0100);
        chk("full_disp_id", disp_id, 8'h40);
        chk("full_ready_back", task_ready, 1);
        step(); task_valid = 0;
        reg_acc(0, 32'h08, 0, 8'hFF, rd, e);
        chk("status_9th_in", rd, 64'h0F08);

        reg_acc(1, 32'h00, 0, 8'hFF, rd, e);
        task_valid = 1; task_id = 8'h99; step();
        chk("disabled_not_ready", task_ready, 0);
        task_valid = 0;
        reg_acc(1, 32'h00, 64'h3, 8'hFE, rd, e);
        reg_acc(0, 32'h00, 0, 8'hFF, rd, e);
        chk("ctrl_be0_masked", rd, 0);
        reg_acc(0, 32'h08, 0, 8'hFF, rd, e);
        chk("status_no_flush", rd, 64'h0F08);
        reg_acc(1, 32'h00, 64'h3, 8'hFF, rd, e);
        reg_acc(0, 32'h08, 0, 8'hFF, rd, e);
        chk("status_flushed", rd, 64'h0F00);
        reg_acc(0, 32'h00, 0, 8'hFF, rd, e);
        chk("ctrl_readback", rd, 1);
        chk("ready_after_flush", task_ready, 1);

        reg_acc(0, 32'h20, 0, 8'hFF, rd, e);
        chk("unmapped_err", e, 1);
        chk("unmapped_rdata", rd, 0);
        reg_acc(1, 32'h10, 0, 8'hFF, rd, e);
        chk("cnt_write_noerr", e, 0);
        reg_acc(0, 32'h10, 0, 8'hFF, rd, e);
        chk("done_cnt_3", rd, 3);
        reg_acc(0, 32'h18, 0, 8'hFF, rd, e);
        chk("last_id_08", rd, 8'h08);

        unit_done = 4'b1111; step(); unit_done = 0;
        push(8'h55); task_valid = 0; step();
        chk("disp_55", disp_id, 8'h55);
        push(8'h56); task_valid = 0;
        rst_n = 0; step();
        chk("midrst_disp_valid", disp_valid, 0);
        chk("midrst_disp_id", disp_id, 0);
        chk("midrst_task_ready", task_ready, 0);
        chk("midrst_task_done", task_done, 0);
        rst_n = 1; step();
        reg_acc(0, 32'h10, 0, 8'hFF, rd, e);
        chk("midrst_done_cnt", rd, 0);
        unit_done = 4'b0001; step(); unit_done = 0;
        reg_acc(0, 32'h08, 0, 8'hFF, rd, e);
        chk("midrst_err", rd, 64'h1_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
